// File: rtl/mantissa_divider_pkg.sv
// ---------------------------------------------------------------------------
// mantissa_divider_pkg
//   Shared definitions for the mantissa divider: the FSM state encoding and
//   the default mantissa width (22 bits including the hidden bit).
// ---------------------------------------------------------------------------
package mantissa_divider_pkg;

  localparam int DEFAULT_WIDTH = 22;

  // Encodings are fixed so that checkers and waveform decoders written
  // against the FP divide unit keep matching.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mantissa_divider_borrow_lookahead_sub.sv
// ---------------------------------------------------------------------------
// borrow_lookahead_sub
//   Combinational N-bit subtractor a - b computed as a + ~b + 1 with a
//   Kogge-Stone parallel-prefix carry network (generate / propagate cells).
//
// Ports
//   a       in   N   minuend
//   b       in   N   subtrahend
//   diff    out  N   a - b (modulo 2^N)
//   borrow  out  1   1 when a < b (inverted carry-out of a + ~b + 1)
// ---------------------------------------------------------------------------
module borrow_lookahead_sub #(
  parameter int N = 23
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         borrow
);

  localparam int LVL = $clog2(N);

  // Level k holds, for each bit i, the group generate/propagate covering
  // bits [i : i-2^k+1]. The propagate term is the XOR form, so level 0 also
  // serves as the half-sum for the final difference.
  for (genvar k = 0; k <= LVL; k++) begin : g_lvl
    logic [N-1:0] g;
    logic [N-1:0] p;
    if (k == 0) begin : g_init
      assign g = a & ~b;
      assign p = a ^ ~b;
    end else begin : g_comb
      localparam int DIST = 1 << (k - 1);
      // Bits below DIST have no partner at this level; their propagate must
      // pass through unchanged, hence the all-ones low mask.
      localparam logic [N-1:0] LOW = {N{1'b1}} >> (N - DIST);
      assign g = g_lvl[k-1].g | (g_lvl[k-1].p & (g_lvl[k-1].g << DIST));
      assign p = g_lvl[k-1].p & ((g_lvl[k-1].p << DIST) | LOW);
    end
  end

  // Carry-in is 1 (the +1 of two's complement), so the carry out of prefix
  // [i:0] is G | P.
  logic [N:0] carry;

  assign carry  = {g_lvl[LVL].g | g_lvl[LVL].p, 1'b1};
  assign diff   = g_lvl[0].p ^ carry[N-1:0];
  assign borrow = ~carry[N];

endmodule

// File: rtl/mantissa_divider.sv
// ---------------------------------------------------------------------------
// mantissa_divider
//   Iterative restoring divider for FP mantissas. Computes
//   Q = floor(dividend * 2^(WIDTH-1) / divisor), one quotient bit per cycle.
//   Divide-by-zero and quotient overflow (dividend >= 2*divisor) complete in
//   one cycle with saturated results.
//
// Handshake: start is a request that is accepted only while the FSM is IDLE;
//   a start seen in CALC or DONE is dropped (no queuing). done is a one-cycle
//   pulse; quotient/remainder/flags are valid from that cycle and held until
//   the results of the next accepted request are written.
//
// Ports
//   clk        in   1      clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   start      in   1      request
//   dividend   in   WIDTH  sampled on accepted start
//   divisor    in   WIDTH  sampled on accepted start
//   busy       out  1      iteration in progress
//   done       out  1      result pulse
//   quotient   out  WIDTH  Q (all ones on dbz/ovf)
//   remainder  out  WIDTH  dividend*2^(WIDTH-1) - Q*divisor
//   dbz        out  1      divisor was zero
//   ovf        out  1      quotient does not fit in WIDTH bits
//   sticky     out  1      remainder != 0 (only with DIV_STICKY_EN defined)
//
// Configuration macro: DIV_STICKY_EN adds the sticky output.
// ---------------------------------------------------------------------------
module mantissa_divider
  import mantissa_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             dbz,
  output logic             ovf
`ifdef DIV_STICKY_EN
  ,
  output logic             sticky
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_next;

  logic [WIDTH:0]   part_rem;   // partial remainder, one bit wider than D
  logic [WIDTH-1:0] div_reg;
  logic [WIDTH-1:0] q_work;
  logic [CW-1:0]    cnt;        // quotient bit being decided this cycle

  logic [WIDTH:0]   diff;
  logic             borrow;
  logic [WIDTH:0]   rem_step;
  logic [WIDTH-1:0] q_step;
  logic             last_step;
  logic             in_dbz;
  logic             in_ovf;

  // Operand classification on the incoming request. ovf is only meaningful
  // for a non-zero divisor; dbz takes priority.
  assign in_dbz    = (divisor == '0);
  assign in_ovf    = !in_dbz && ({1'b0, dividend} >= {divisor, 1'b0});
  assign last_step = (cnt == '0);

  borrow_lookahead_sub #(
    .N (WIDTH + 1)
  ) u_sub (
    .a      (part_rem),
    .b      ({1'b0, div_reg}),
    .diff   (diff),
    .borrow (borrow)
  );

  // One restoring step: keep the difference when it did not borrow.
  always_comb begin
    rem_step    = borrow ? part_rem : diff;
    q_step      = q_work;
    q_step[cnt] = ~borrow;
  end

  // Next-state and status outputs.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = (in_dbz || in_ovf) ? ST_DONE : ST_CALC;
        end
      end
      ST_CALC: begin
        busy = 1'b1;
        if (last_step) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Datapath and result registers. Results are written on the edge that
  // enters DONE so they are already valid while done is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      part_rem  <= '0;
      div_reg   <= '0;
      q_work    <= '0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
      dbz       <= 1'b0;
      ovf       <= 1'b0;
`ifdef DIV_STICKY_EN
      sticky    <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            dbz      <= in_dbz;
            ovf      <= in_ovf;
            div_reg  <= divisor;
            part_rem <= {1'b0, dividend};
            cnt      <= CNT_INIT;
            q_work   <= '0;
            if (in_dbz) begin
              quotient  <= '1;
              remainder <= dividend;
`ifdef DIV_STICKY_EN
              sticky    <= 1'b1;
`endif
            end else if (in_ovf) begin
              quotient  <= '1;
              remainder <= '0;
`ifdef DIV_STICKY_EN
              sticky    <= 1'b0;
`endif
            end
          end
        end
        ST_CALC: begin
          q_work <= q_step;
          if (!last_step) begin
            // rem_step < divisor < 2^WIDTH, so the shift cannot lose a bit.
            part_rem <= {rem_step[WIDTH-1:0], 1'b0};
            cnt      <= cnt - CW'(1);
          end else begin
            quotient  <= q_step;
            remainder <= rem_step[WIDTH-1:0];
`ifdef DIV_STICKY_EN
            sticky    <= |rem_step;
`endif
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mantissa_divider.sv
// ---------------------------------------------------------------------------
// tb_mantissa_divider
//   Self-checking bench for mantissa_divider (WIDTH=22). Expected results
//   come from a plain-arithmetic reference of floor(a*2^21/b).
// ---------------------------------------------------------------------------
module tb_mantissa_divider;

  localparam int W = 22;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         dbz;
  logic         ovf;
`ifdef DIV_STICKY_EN
  logic         sticky;
`endif

  int checks = 0;
  int errors = 0;

  mantissa_divider #(
    .WIDTH (W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .dbz       (dbz),
    .ovf       (ovf)
`ifdef DIV_STICKY_EN
    ,
    .sticky    (sticky)
`endif
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: exact integer division of dividend*2^(W-1) by divisor.
  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic z, output logic o);
    longint unsigned num;
    longint unsigned qq;
    longint unsigned rr;
    if (b == '0) begin
      q = '1; r = a; z = 1'b1; o = 1'b0;
    end else begin
      num = longint'(a) << (W - 1);
      qq  = num / longint'(b);
      rr  = num % longint'(b);
      if (qq >= (64'd1 << W)) begin
        q = '1; r = '0; z = 1'b0; o = 1'b1;
      end else begin
        q = qq[W-1:0]; r = rr[W-1:0]; z = 1'b0; o = 1'b0;
      end
    end
  endfunction

  // Drive one request, wait for done with a cycle budget and score it.
  // Cycle 1 is the cycle after the accepting edge. With noise set, start is
  // pulsed with other operands during the computation.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit noise,
                        input string tag);
    logic [W-1:0] eq;
    logic [W-1:0] er;
    logic         ez;
    logic         eo;
    int           cyc;
    int           lat;
    ref_div(a, b, eq, er, ez, eo);
    lat = (ez || eo) ? 1 : W + 1;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
    cyc = 1;
    check({tag, ":busy_c1"}, 64'(busy), 64'(lat != 1));
    while (!done && cyc < W + 10) begin
      if (noise && cyc >= 2 && cyc <= 10) begin
        start    = 1'b1;
        dividend = W'($urandom);
        divisor  = W'($urandom);
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    start = 1'b0;
    check({tag, ":done_seen"}, 64'(done), 64'd1);
    check({tag, ":latency"}, 64'(cyc), 64'(lat));
    check({tag, ":busy_done"}, 64'(busy), 64'd0);
    check({tag, ":quotient"}, 64'(quotient), 64'(eq));
    check({tag, ":remainder"}, 64'(remainder), 64'(er));
    check({tag, ":dbz"}, 64'(dbz), 64'(ez));
    check({tag, ":ovf"}, 64'(ovf), 64'(eo));
`ifdef DIV_STICKY_EN
    check({tag, ":sticky"}, 64'(sticky), 64'(ez || (er != '0)));
`endif
    @(posedge clk);
    #1;
    check({tag, ":done_pulse"}, 64'(done), 64'd0);
    check({tag, ":q_hold"}, 64'(quotient), 64'(eq));
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    int           extra_done;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst:busy", 64'(busy), 64'd0);
    check("rst:done", 64'(done), 64'd0);
    check("rst:quotient", 64'(quotient), 64'd0);
    check("rst:remainder", 64'(remainder), 64'd0);
    check("rst:dbz", 64'(dbz), 64'd0);
    check("rst:ovf", 64'(ovf), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1) exact quotient
    run_op(22'h300000, 22'h200000, 1'b0, "t1");
    check("t1:q_lit", 64'(quotient), 64'h300000);
    // 2) non-terminating quotient
    run_op(22'h200000, 22'h300000, 1'b0, "t2");
    check("t2:q_lit", 64'(quotient), 64'h155555);
    check("t2:r_lit", 64'(remainder), 64'h100000);
    // 3) largest in-range quotient, then overflow by one LSB of divisor
    run_op(22'h3FFFFF, 22'h200000, 1'b0, "t3a");
    check("t3a:q_lit", 64'(quotient), 64'h3FFFFF);
    run_op(22'h3FFFFF, 22'h1FFFFF, 1'b0, "t3b");
    check("t3b:ovf_lit", 64'(ovf), 64'd1);
    // 4) divide by zero
    run_op(22'h2AAAAA, 22'h000000, 1'b0, "t4");
    check("t4:r_lit", 64'(remainder), 64'h2AAAAA);
    // flags must clear on the next accepted start
    run_op(22'h250000, 22'h300000, 1'b0, "t4clr");
    // 5) start pulses while calculating are ignored, no second done
    run_op(22'h2D1234, 22'h3A5A5A, 1'b1, "t5");
    extra_done = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) extra_done++;
    end
    check("t5:no_queued_op", 64'(extra_done), 64'd0);

    // reset in the middle of a calculation
    @(negedge clk);
    dividend = 22'h3C0F0F;
    divisor  = 22'h2F0000;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("abort:busy_before", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("abort:busy", 64'(busy), 64'd0);
    check("abort:done", 64'(done), 64'd0);
    check("abort:quotient", 64'(quotient), 64'd0);
    check("abort:remainder", 64'(remainder), 64'd0);
    check("abort:flags", 64'({dbz, ovf}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(22'h3C0F0F, 22'h2F0000, 1'b0, "fresh");

    // non-normalized corner: smallest non-zero operands
    run_op(22'h000001, 22'h000001, 1'b0, "tiny");

    // randomized operands
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 9))
        0:       rb = '0;
        1, 2:    rb = W'($urandom);
        default: rb = W'($urandom) | 22'h200000;
      endcase
      ra = W'($urandom);
      if ($urandom_range(0, 1) == 1) ra = ra | 22'h200000;
      run_op(ra, rb, ($urandom_range(0, 3) == 0), $sformatf("rnd%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
